ysyx_23060201_lsu_ctrl: RTL
===========================

# ysyx_23060201_lsu_ctrl

Multi-cycle load/store controller between the execute unit and the data-memory bus. Accepts one memory command per handshake from EXU: load/store enables, address, mask, store data. Drives a valid/ready request/response bus with byte-lane alignment and load sign/zero extension. Reports completion, with an error flag, to writeback. Stalls the core by deasserting `in_ready` while a transaction is outstanding.

## Interface
- `DATA_WIDTH`, 32, data and bus width; fixed at 32.
- `ADDR_WIDTH`, 32, address width.
- `TIMEOUT`, 255, maximum cycles to wait in RSP; 0 disables the timeout. Counter is 8 bits.

- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  EXU command valid.
- `in_ready`  out  1  controller can accept a command.
- `mem_ren`, `mem_wen`  in  1 each  load / store request.
- `mem_raddr`, `mem_waddr`  in  ADDR_WIDTH  load / store address.
- `mem_rmask`  in  8  bits[3:0] select size (0001 byte, 0011 half, 1111 word); bit4=1 selects sign-extend.
- `mem_wmask`  in  8  bits[3:0] store size, same encoding; bits[7:4] ignored.
- `mem_wdata`  in  DATA_WIDTH  store data, LSB-aligned.
- `req_valid`  out  1  bus request valid.
- `req_ready`  in  1  bus accepts the request.
- `req_wen`  out  1  1 = write, 0 = read.
- `req_addr`  out  ADDR_WIDTH  unmodified byte address.
- `req_wdata`  out  DATA_WIDTH  store data shifted to its byte lane.
- `req_wstrb`  out  4  byte strobes.
- `rsp_valid`  in  1  bus response valid.
- `rsp_ready`  out  1  controller accepts the response.
- `rsp_rdata`  in  DATA_WIDTH  read word, word-aligned.
- `rsp_err`  in  1  bus error.
- `out_valid`  out  1  command complete.
- `out_ready`  in  1  writeback consumes the result.
- `out_rdata`  out  DATA_WIDTH  extended load data; 0 for stores, non-memory commands and errors.
- `out_err`  out  1  misaligned, illegal mask, both enables set, bus error or timeout.

## Operation
- FSM states: IDLE, REQ, RSP, DONE. Reset state is IDLE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`, latch the command.
  - If `mem_ren`=`mem_wen`=0, go to DONE with `out_rdata`=0, `out_err`=0.
  - If both enables are set, go to DONE with `out_err`=1.
  - If the mask's bits[3:0] are not one of 0001/0011/1111, go to DONE with `out_err`=1.
  - If the access is misaligned (half with addr[0]=1, or word with addr[1:0]≠0), go to DONE with `out_err`=1.
  - Otherwise go to REQ.
- **Request fields**
  - Address: load uses `mem_raddr`, store uses `mem_waddr`; `off` = addr[1:0].
  - `req_wstrb` = mask[3:0] << `off`.
  - `req_wdata` = `mem_wdata` << (8·`off`).
  - For reads, `req_wstrb` and `req_wdata` are 0.
- **REQ**
  - `req_valid`=1, held with stable fields until `req_ready`.
  - `req_valid` & `req_ready` → RSP; clear the timeout counter.
- **RSP**
  - `rsp_ready`=1.
  - On `rsp_valid`, capture the result and go to DONE.
  - Load data: `sh` = `rsp_rdata` >> (8·`off`), then truncate to the access size.
  - Sign-extend when rmask bit4=1, zero-extend otherwise. Stores give 0.
  - `out_err` = `rsp_err`; `out_rdata` is forced to 0 when `rsp_err`=1.
  - Without `rsp_valid`, the counter increments. When the counter equals `TIMEOUT`-1 (with `TIMEOUT`≠0), go to DONE with `out_err`=1. A late response is then dropped: `rsp_ready`=0 outside RSP.
- **DONE**
  - `out_valid`=1; `out_rdata` and `out_err` are held stable.
  - On `out_ready` → IDLE.
- `rsp_valid` arriving in REQ is ignored; the bus must not respond before accepting the request.

## Timing
- During `rst`, and on the first cycle after it, all registered outputs are 0.
  - This covers `req_valid`, `req_wen`, `req_addr`, `req_wdata`, `req_wstrb`, `out_valid`, `out_rdata` and `out_err`.
  - `in_ready` and `rsp_ready` are decoded from state. `in_ready` is forced to 0 while `rst`=1.
- Reset mid-transaction returns to IDLE on the next edge.
  - The outstanding bus transaction is abandoned; the bus is reset by the same `rst`.
  - Latched command, captured data and counter are cleared.
- Accept to `out_valid`, memory command, zero-wait bus: 3 cycles.
  - Edge 1: IDLE→REQ.
  - Edge 2: REQ→RSP.
  - Edge 3: RSP→DONE.
- Accept to `out_valid`, non-memory or error command: 1 cycle.
- Each extra `req_ready` or `rsp_valid` wait cycle adds one cycle.
- Throughput:
  - With `out_ready` held at 1, DONE lasts 1 cycle.
  - A new command is accepted in the cycle after DONE.
  - Best case is one load/store per 4 cycles, one non-memory command per 2 cycles.
- `out_ready`=0 holds DONE indefinitely. No new command is accepted (`in_ready`=0).
- Timeout: with `TIMEOUT`=T, DONE is entered T cycles after entering RSP when no response arrives.

## Test plan
- Store byte, `mem_waddr`=0x80000003, `mem_wdata`=0x000000AB, mask 0001, zero-wait bus → `req_wen`=1, `req_wstrb`=1000, `req_wdata`=0xAB000000, `out_valid` 3 cycles after accept, `out_err`=0.
- Load byte signed, addr 0x80000002, rmask 10001, `rsp_rdata`=0x12F45678 → `out_rdata`=0xFFFFFFF4. Same with rmask 00001 → 0x000000F4.
- Load half at 0x80000001 → no `req_valid`, `out_valid` next cycle with `out_err`=1. Same for a word at 0x80000002.
- `req_ready` held low 3 cycles, then `rsp_valid` delayed 2 cycles → fields stable in REQ, `out_valid` 8 cycles after accept. `in_ready`=0 throughout.
- `TIMEOUT`=4, no `rsp_valid` → DONE 4 cycles after RSP entry, `out_err`=1, `out_rdata`=0. A later `rsp_valid` is ignored.
- `rst` asserted during RSP → next cycle IDLE, all outputs 0. `in_ready`=1 once `rst` deasserts, and the next command completes normally.

Source files
------------

// File: rtl/ysyx_23060201_lsu_ctrl.sv
// Load/store controller: EXU command -> valid/ready data bus, with byte-lane
// alignment, load extension and a bounded wait for the bus response.
module ysyx_23060201_lsu_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  mem_ren,
    input  logic                  mem_wen,
    input  logic [ADDR_WIDTH-1:0] mem_raddr,
    input  logic [ADDR_WIDTH-1:0] mem_waddr,
    input  logic [7:0]            mem_rmask,
    input  logic [7:0]            mem_wmask,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  req_valid,
    input  logic                  req_ready,
    output logic                  req_wen,
    output logic [ADDR_WIDTH-1:0] req_addr,
    output logic [DATA_WIDTH-1:0] req_wdata,
    output logic [3:0]            req_wstrb,
    input  logic                  rsp_valid,
    output logic                  rsp_ready,
    input  logic [DATA_WIDTH-1:0] rsp_rdata,
    input  logic                  rsp_err,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_rdata,
    output logic                  out_err
);

    typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} state_e;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_e                state_q, state_d;
    logic                  req_wen_q, req_wen_d;
    logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
    logic [DATA_WIDTH-1:0] req_wdata_q, req_wdata_d;
    logic [3:0]            req_wstrb_q, req_wstrb_d;
    logic [3:0]            size_q, size_d;
    logic                  sext_q, sext_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] out_rdata_q, out_rdata_d;
    logic                  out_err_q, out_err_d;

    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [7:0]            cmd_mask;
    logic [1:0]            cmd_off;
    logic                  is_b, is_h, is_w;
    logic                  cmd_mem, cmd_err;
    logic [DATA_WIDTH-1:0] sh, ld_data;
    logic                  unused_mask;

    assign unused_mask = ^{mem_wmask[7:4], mem_rmask[7:5]};

    always_comb begin
        cmd_addr = mem_wen ? mem_waddr : mem_raddr;
        cmd_mask = mem_wen ? mem_wmask : mem_rmask;
        cmd_off  = cmd_addr[1:0];
        is_b     = (cmd_mask[3:0] == 4'b0001);
        is_h     = (cmd_mask[3:0] == 4'b0011);
        is_w     = (cmd_mask[3:0] == 4'b1111);
        cmd_mem  = mem_ren | mem_wen;
        cmd_err  = (mem_ren & mem_wen)
                 | (cmd_mem & ~(is_b | is_h | is_w))
                 | (cmd_mem & is_h & cmd_off[0])
                 | (cmd_mem & is_w & (cmd_off != 2'b00));
    end

    // Response word is word-aligned; move the addressed lane down first.
    always_comb begin
        sh = rsp_rdata >> {req_addr_q[1:0], 3'b000};
        unique case (size_q)
            4'b1111: ld_data = sh;
            4'b0011: ld_data = {{(DATA_WIDTH-16){sext_q & sh[15]}}, sh[15:0]};
            default: ld_data = {{(DATA_WIDTH-8){sext_q & sh[7]}}, sh[7:0]};
        endcase
    end

    always_comb begin
        state_d     = state_q;
        req_wen_d   = req_wen_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        req_wstrb_d = req_wstrb_q;
        size_d      = size_q;
        sext_d      = sext_q;
        cnt_d       = cnt_q;
        out_rdata_d = out_rdata_q;
        out_err_d   = out_err_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    req_wen_d   = mem_wen;
                    req_addr_d  = cmd_addr;
                    req_wdata_d = mem_wen ? (mem_wdata << {cmd_off, 3'b000}) : '0;
                    req_wstrb_d = mem_wen ? (cmd_mask[3:0] << cmd_off) : 4'b0000;
                    size_d      = cmd_mask[3:0];
                    sext_d      = mem_rmask[4];
                    cnt_d       = '0;
                    out_rdata_d = '0;
                    out_err_d   = cmd_err;
                    state_d     = (cmd_mem && !cmd_err) ? REQ : DONE;
                end
            end
            REQ: begin
                if (req_ready) begin
                    cnt_d   = '0;
                    state_d = RSP;
                end
            end
            RSP: begin
                if (rsp_valid) begin
                    out_err_d   = rsp_err;
                    out_rdata_d = (rsp_err || req_wen_q) ? '0 : ld_data;
                    state_d     = DONE;
                end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
                    out_err_d   = 1'b1;
                    out_rdata_d = '0;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            req_wen_q   <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_wstrb_q <= '0;
            size_q      <= '0;
            sext_q      <= 1'b0;
            cnt_q       <= '0;
            out_rdata_q <= '0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_wen_q   <= req_wen_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            req_wstrb_q <= req_wstrb_d;
            size_q      <= size_d;
            sext_q      <= sext_d;
            cnt_q       <= cnt_d;
            out_rdata_q <= out_rdata_d;
            out_err_q   <= out_err_d;
        end
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign req_valid = (state_q == REQ);
    assign rsp_ready = (state_q == RSP);
    assign out_valid = (state_q == DONE);
    assign req_wen   = req_wen_q;
    assign req_addr  = req_addr_q;
    assign req_wdata = req_wdata_q;
    assign req_wstrb = req_wstrb_q;
    assign out_rdata = out_rdata_q;
    assign out_err   = out_err_q;

endmodule
